// File: rtl/seg_bcd_ctrl.sv
// seg_bcd_ctrl
// Sequential binary-to-BCD converter feeding an eight-digit seven-segment
// decoder. A 32-bit value is accepted over valid/ready and converted with
// double dabble (add-3 then shift), one bit per clock, 32 clocks total.
// The eight BCD digits, a per-digit blank mask and an overflow flag are
// latched when the conversion completes and held until the next one.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   producer offers in_data
//   in_ready   high when idle and not in reset
//   in_data    32-bit unsigned value to convert
//   out_valid  one-cycle pulse when digits/blank/overflow were just loaded
//   digits     eight BCD nibbles, ones digit at [3:0]
//   blank      bit i set means the decoder blanks digit i
//   overflow   last value exceeded 99,999,999 (digits clamp to all nines)
//   busy       conversion in progress
//
// Build option
//   SEG_LZ_BLANK_EN  when defined, leading zeros are blanked (digit 0 is
//                    never blanked); otherwise blank is always 8'h00.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for in_valid; outputs hold the last result
// SHIFT | one add-3/shift step per clock, 32 steps, then load outputs

module seg_bcd_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    output logic [31:0] digits,
    output logic [7:0]  blank,
    output logic        overflow,
    output logic        busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

`ifdef SEG_LZ_BLANK_EN
    localparam logic [7:0] BLANK_RST = 8'hFE;
`else
    localparam logic [7:0] BLANK_RST = 8'h00;
`endif

    state_t      state;
    logic [31:0] shreg;
    logic [39:0] scratch;
    logic [4:0]  cnt;

    logic [39:0] adj;
    logic [40:0] shifted;
    logic [39:0] scratch_nxt;
    logic        ovf_nxt;
    logic [7:0]  blank_nxt;

    // Add 3 to every nibble >= 5 so that the following shift carries
    // correctly into the next decimal digit.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < 10; i++) begin
            if (scratch[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Bit 40 can never be set for valid BCD, but folding it into the
    // overflow test keeps every adjusted bit observable.
    assign shifted     = {adj, shreg[31]};
    assign scratch_nxt = shifted[39:0];
    assign ovf_nxt     = |shifted[40:32];

`ifdef SEG_LZ_BLANK_EN
    logic zero_above;

    always_comb begin
        blank_nxt  = 8'h00;
        zero_above = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            zero_above   = zero_above & (scratch_nxt[i*4 +: 4] == 4'd0);
            blank_nxt[i] = zero_above;
        end
        if (ovf_nxt) begin
            blank_nxt = 8'h00;
        end
    end
`else
    assign blank_nxt = 8'h00;
`endif

    assign in_ready = (state == IDLE) && !rst;
    assign busy     = (state == SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= 32'h0;
            scratch   <= 40'h0;
            cnt       <= 5'd0;
            out_valid <= 1'b0;
            digits    <= 32'h0;
            blank     <= BLANK_RST;
            overflow  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg   <= in_data;
                        scratch <= 40'h0;
                        cnt     <= 5'd0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= scratch_nxt;
                    shreg   <= {shreg[30:0], 1'b0};
                    cnt     <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state     <= IDLE;
                        out_valid <= 1'b1;
                        blank     <= blank_nxt;
                        overflow  <= ovf_nxt;
                        digits    <= ovf_nxt ? 32'h99999999 : scratch_nxt[31:0];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/seg_bcd_ctrl.md
# seg_bcd_ctrl

Sequential binary-to-BCD conversion controller that sits between the 32-bit value producer and the eight-digit seven-segment decoder. It accepts a binary value through a valid/ready handshake and converts it with iterative shift-add-3 (double dabble), one bit per cycle. It presents eight latched BCD digits, a per-digit blank mask and an overflow flag to the decoder stage, and holds them until the next conversion completes.

## Interface
- No parameters; widths are fixed.
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  producer offers in_data
- in_ready  out  1  controller can accept; high exactly when state is IDLE and rst is low
- in_data  in  32  unsigned binary value
- out_valid  out  1  one-cycle pulse: digits/blank/overflow just updated
- digits  out  32  eight BCD nibbles, digit 0 (ones) at [3:0], digit 7 at [31:28]
- blank  out  8  bit i high means the decoder blanks digit i
- overflow  out  1  last converted value exceeded 99,999,999
- busy  out  1  high in SHIFT

## Operation
- States: IDLE, SHIFT.
- IDLE: in_ready=1. When in_valid is high, capture in_data into a 32-bit shift register, clear a 40-bit (10-nibble) BCD scratch register, clear the 5-bit bit counter, and go to SHIFT.
- SHIFT: each cycle, add 3 to every scratch nibble that is ≥5, then shift {scratch, shiftreg} left by one bit. Increment the counter. After the 32nd shift, return to IDLE and load the outputs.
- Output load:
  - If scratch nibbles 9..8 are nonzero, set overflow=1, digits=32'h99999999 and blank=8'h00.
  - Otherwise set overflow=0, digits=scratch[31:0], and compute blank as described under Configuration.
- Assert out_valid for that single cycle.
- Outputs hold their last loaded values until the next load or reset.
- in_valid while busy is ignored. in_data is not sampled and no request is queued.
- The scratch register is 40 bits so that all 32-bit inputs convert without internal loss. Only the output clamps.

## Timing
- Reset values:
  - in_ready = 0 while rst is high, and 1 in the first cycle after it is released.
  - busy = 0, out_valid = 0, overflow = 0, digits = 32'h0.
  - blank = 8'hFE with SEG_LZ_BLANK_EN defined, 8'h00 without it.
- Let edge E0 be the edge that accepts the handshake (in_valid && in_ready).
  - Edges E1..E32 perform the 32 shifts.
  - busy is high from after E0 through E32.
  - At E32 the outputs load and out_valid rises; it falls at E33.
  - in_ready is high again in the cycle after E32, in the same cycle as out_valid.
- Latency from the accepting edge to out_valid: 32 cycles.
- Maximum throughput: one conversion per 33 cycles. A new request may be accepted at E33.
- Reset mid-conversion: the conversion is aborted, out_valid does not pulse, and all outputs take their reset values at the next edge.
- Simultaneous rst and in_valid: reset wins and nothing is captured.

## Configuration
- SEG_LZ_BLANK_EN
  - Defined: leading-zero suppression.
    - blank[i]=1 for i in 1..7 when digits i..7 are all zero.
    - blank[0] is always 0, so a value of 0 displays a single "0".
    - blank is 8'h00 on overflow.
  - Not defined: blank is tied to 8'h00 and all eight digits are always shown.

## Test plan
- Reset: hold rst for 2 cycles, then release. Required: digits=0, overflow=0, out_valid=0, busy=0, blank=8'hFE (macro defined) or 8'h00 (not defined), and in_ready=1 in the first cycle after release.
- Value 123: in_data=32'd123 accepted at E0. Required: out_valid pulses only at E32, digits=32'h00000123, overflow=0, blank=8'hF8 (macro defined) or 8'h00 (not defined).
- Upper bound: in_data=32'd99999999 gives digits=32'h99999999, overflow=0, blank=8'h00. in_data=32'd100000000 and in_data=32'hFFFFFFFF each give overflow=1, digits=32'h99999999, blank=8'h00.
- Zero and hold: in_data=0 gives digits=0 and blank=8'hFE (macro defined). Outputs must stay stable for 100 idle cycles afterwards.
- Busy ignore and back-to-back:
  - Hold in_valid high with data 5, then change the data to 7 during SHIFT.
  - Required: the first result is 5, and 7 is accepted at E33.
  - Required: the second out_valid pulse arrives 33 cycles after the first, with digits=32'h00000007.
- Mid-conversion reset: pulse rst during the 10th SHIFT cycle of a conversion of 4321. Required: no out_valid, outputs at reset values, and a subsequent conversion of 42 yields 32'h00000042.
